perip_pwm_multi: RTL and testbench

- Parametrised successor to the fixed BZ/RGB-LED PWM peripheral: N independent PWM channels sharing one period counter, configured through a register interface.
- Register interface is driven by the FlexBus register slave after that slave has synchronised into the CLK domain.
- Adds programmable polarity, per-channel enable, an edge- or centre-aligned mode, glitch-free shadowed updates and read-back.

---
 rtl/perip_pwm_multi.sv | 191 +++++++++++++++++++
 tb/tb_perip_pwm_multi.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/perip_pwm_multi.sv
// Purpose: NCH-channel PWM sharing one period counter, with a register interface and shadowed, glitch-free updates.
// Latency: PWM_OUT and PERIOD_IRQ are registered one cycle after the counter value; RD_DATA/RD_VALID follow RD_EN by one cycle.
// Backpressure: none; every WR_EN/RD_EN strobe is accepted in the cycle it is presented.
module perip_pwm_multi #(
  parameter int NCH    = 4,
  parameter int CNT_W  = 16,
  parameter int ADDR_W = 5
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              WR_EN,
  input  logic              RD_EN,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic [31:0]       WR_DATA,
  output logic [31:0]       RD_DATA,
  output logic              RD_VALID,
  output logic [NCH-1:0]    PWM_OUT,
  output logic              PERIOD_IRQ
);

  localparam logic [ADDR_W-1:0] A_CTRL   = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] A_PERIOD = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_CH_EN  = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] A_CH_POL = ADDR_W'(3);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_t;

  // programmed registers (what software wrote)
  logic             gen;
  logic             mode;
  logic [CNT_W-1:0] period_r;
  logic [NCH-1:0]   ch_en_r;
  logic [NCH-1:0]   ch_pol_r;
  logic [CNT_W-1:0] duty_r [NCH];

  // shadows actually used by the counter and the compare logic
  logic             mode_sh;
  logic [CNT_W-1:0] period_sh;
  logic [NCH-1:0]   ch_en_sh;
  logic [NCH-1:0]   ch_pol_sh;
  logic [CNT_W-1:0] duty_sh [NCH];

  logic [CNT_W-1:0] cnt, cnt_nxt;
  dir_t             dir, dir_nxt;
  logic             load_pt;
  logic             shadow_ld;
  logic [NCH-1:0]   pwm_nxt;
  logic [31:0]      rd_mux;

  // register file writes; unmapped addresses and unused bits are dropped
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      gen      <= 1'b0;
      mode     <= 1'b0;
      period_r <= '0;
      ch_en_r  <= '0;
      ch_pol_r <= '0;
      for (int i = 0; i < NCH; i++) duty_r[i] <= '0;
    end else if (WR_EN) begin
      case (ADDR)
        A_CTRL: begin
          gen  <= WR_DATA[0];
          mode <= WR_DATA[1];
        end
        A_PERIOD: period_r <= WR_DATA[CNT_W-1:0];
        A_CH_EN:  ch_en_r  <= WR_DATA[NCH-1:0];
        A_CH_POL: ch_pol_r <= WR_DATA[NCH-1:0];
        default: ;
      endcase
      for (int i = 0; i < NCH; i++)
        if (ADDR == ADDR_W'(4 + i)) duty_r[i] <= WR_DATA[CNT_W-1:0];
    end
  end

  // counter and direction state register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt <= '0;
      dir <= DIR_UP;
    end else begin
      cnt <= cnt_nxt;
      dir <= dir_nxt;
    end
  end

  // next count, direction and load-point detection for both alignment modes
  always_comb begin
    load_pt = 1'b0;
    cnt_nxt = cnt;
    dir_nxt = dir;
    if (!gen) begin
      cnt_nxt = '0;
      dir_nxt = DIR_UP;
    end else if (!mode_sh) begin
      if (cnt >= period_sh) begin
        load_pt = 1'b1;
        cnt_nxt = '0;
        dir_nxt = DIR_UP;
      end else begin
        cnt_nxt = cnt + CNT_ONE;
      end
    end else begin
      if ((period_sh == '0) || (dir == DIR_DOWN && cnt == '0)) begin
        // the zero just seen closes this period, so the next period starts at 1
        // (sized by the period value being loaded now)
        load_pt = 1'b1;
        cnt_nxt = (period_r == '0) ? '0 : CNT_ONE;
        dir_nxt = DIR_UP;
      end else if (dir == DIR_UP) begin
        if (cnt >= period_sh) begin
          cnt_nxt = cnt - CNT_ONE;
          dir_nxt = DIR_DOWN;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end else begin
        cnt_nxt = cnt - CNT_ONE;
      end
    end
    // a mode switch lands at the load point and restarts the count cleanly
    if (load_pt && (mode != mode_sh)) begin
      cnt_nxt = '0;
      dir_nxt = DIR_UP;
    end
  end

  assign shadow_ld = load_pt | ~gen;

  // shadow capture at load points, or continuously while disabled
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      mode_sh   <= 1'b0;
      period_sh <= '0;
      ch_en_sh  <= '0;
      ch_pol_sh <= '0;
      for (int i = 0; i < NCH; i++) duty_sh[i] <= '0;
    end else if (shadow_ld) begin
      mode_sh   <= mode;
      period_sh <= period_r;
      ch_en_sh  <= ch_en_r;
      ch_pol_sh <= ch_pol_r;
      for (int i = 0; i < NCH; i++) duty_sh[i] <= duty_r[i];
    end
  end

  // per-channel compare with polarity; disabled generator parks at the inactive level
  always_comb begin
    pwm_nxt = ch_pol_sh;
    if (gen)
      for (int i = 0; i < NCH; i++)
        pwm_nxt[i] = (ch_en_sh[i] & (cnt < duty_sh[i])) ^ ch_pol_sh[i];
  end

  // registered channel outputs and period interrupt
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      PWM_OUT    <= '0;
      PERIOD_IRQ <= 1'b0;
    end else begin
      PWM_OUT    <= pwm_nxt;
      PERIOD_IRQ <= load_pt;
    end
  end

  // read mux over the programmed (not shadow) registers
  always_comb begin
    rd_mux = '0;
    case (ADDR)
      A_CTRL:   rd_mux = {30'd0, mode, gen};
      A_PERIOD: rd_mux = 32'(period_r);
      A_CH_EN:  rd_mux = 32'(ch_en_r);
      A_CH_POL: rd_mux = 32'(ch_pol_r);
      default: ;
    endcase
    for (int i = 0; i < NCH; i++)
      if (ADDR == ADDR_W'(4 + i)) rd_mux = 32'(duty_r[i]);
  end

  // registered read data, held between reads
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      RD_DATA  <= '0;
      RD_VALID <= 1'b0;
    end else begin
      RD_VALID <= RD_EN;
      if (RD_EN) RD_DATA <= rd_mux;
    end
  end

endmodule

// File: tb/tb_perip_pwm_multi.sv
// Purpose: randomized and directed checks of perip_pwm_multi against a phase-based reference model.
// Latency: model predicts outputs one clock after each set of inputs is applied.
// Backpressure: not applicable; the bench drives one register strobe per cycle at most.
module tb_perip_pwm_multi;
  localparam int NCH    = 4;
  localparam int CNT_W  = 16;
  localparam int ADDR_W = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic              wr_en, rd_en;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wr_data;
  logic [31:0]       rd_data;
  logic              rd_valid;
  logic [NCH-1:0]    pwm_out;
  logic              period_irq;

  perip_pwm_multi #(.NCH(NCH), .CNT_W(CNT_W), .ADDR_W(ADDR_W)) dut (
    .CLK(clk), .RST(rst), .WR_EN(wr_en), .RD_EN(rd_en), .ADDR(addr),
    .WR_DATA(wr_data), .RD_DATA(rd_data), .RD_VALID(rd_valid),
    .PWM_OUT(pwm_out), .PERIOD_IRQ(period_irq)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model: programmed registers, shadows, and position within the period
  logic             m_gen, m_mode, s_mode;
  logic [CNT_W-1:0] m_per, s_per;
  logic [NCH-1:0]   m_en, m_pol, s_en, s_pol;
  logic [CNT_W-1:0] m_duty [NCH];
  logic [CNT_W-1:0] s_duty [NCH];
  longint           t;       // cycles since the current period began
  bit               fresh;   // centre mode: t==0 is the start after enable/mode switch, not a period end
  logic [NCH-1:0]   exp_pwm;
  logic             exp_irq, exp_rdv;
  logic [31:0]      exp_rdd;
  logic [NCH-1:0]   obs_pwm;
  logic             obs_irq;

  task automatic model_reset();
    m_gen = 0; m_mode = 0; s_mode = 0; m_per = '0; s_per = '0;
    m_en = '0; m_pol = '0; s_en = '0; s_pol = '0;
    for (int i = 0; i < NCH; i++) begin m_duty[i] = '0; s_duty[i] = '0; end
    t = 0; fresh = 1;
    exp_pwm = '0; exp_irq = 0; exp_rdv = 0; exp_rdd = '0;
  endtask

  function automatic logic [31:0] reg_read(input logic [ADDR_W-1:0] a);
    int idx;
    idx = int'(a) - 4;
    if (a == 0) return {30'd0, m_mode, m_gen};
    if (a == 1) return 32'(m_per);
    if (a == 2) return 32'(m_en);
    if (a == 3) return 32'(m_pol);
    if (idx >= 0 && idx < NCH) return 32'(m_duty[idx]);
    return 32'd0;
  endfunction

  // advance the model by one clock with the given inputs
  task automatic model_step(input logic we, input logic re, input logic [ADDR_W-1:0] a, input logic [31:0] d);
    longint cnt, p;
    bit     load;
    int     idx;
    p = longint'(s_per);
    if (!s_mode) begin
      cnt = t; load = m_gen && (t == p);
    end else if (p == 0) begin
      cnt = 0; load = m_gen;
    end else begin
      cnt = (t <= p) ? t : 2 * p - t;          // triangle: up to p, back down
      load = m_gen && (t == 0) && !fresh;
    end
    for (int i = 0; i < NCH; i++)
      exp_pwm[i] = m_gen ? ((s_en[i] && (cnt < longint'(s_duty[i]))) ^ s_pol[i]) : s_pol[i];
    exp_irq = load;
    exp_rdv = re;
    if (re) exp_rdd = reg_read(a);
    // where the next cycle sits in the period
    if (!m_gen) begin
      t = 0; fresh = 1;
    end else if (load) begin
      if (s_mode != m_mode) begin t = 0; fresh = 1; end
      else if (!s_mode) t = 0;
      else begin t = (m_per == 0) ? 0 : 1; fresh = 0; end
    end else if (!s_mode) begin
      t = t + 1;
    end else begin
      t = (t + 1) % (2 * p); fresh = 0;
    end
    if (load || !m_gen) begin
      s_mode = m_mode; s_per = m_per; s_en = m_en; s_pol = m_pol;
      for (int i = 0; i < NCH; i++) s_duty[i] = m_duty[i];
    end
    if (we) begin
      idx = int'(a) - 4;
      if (a == 0) begin m_gen = d[0]; m_mode = d[1]; end
      else if (a == 1) m_per = d[CNT_W-1:0];
      else if (a == 2) m_en = d[NCH-1:0];
      else if (a == 3) m_pol = d[NCH-1:0];
      else if (idx >= 0 && idx < NCH) m_duty[idx] = d[CNT_W-1:0];
    end
  endtask

  // check the outputs of the previous cycle, then present new inputs
  task automatic step(input logic we, input logic re, input logic [ADDR_W-1:0] a, input logic [31:0] d);
    @(negedge clk);
    obs_pwm = pwm_out;
    obs_irq = period_irq;
    chk("pwm_out", 32'(pwm_out), 32'(exp_pwm));
    chk("period_irq", 32'(period_irq), 32'(exp_irq));
    chk("rd_valid", 32'(rd_valid), 32'(exp_rdv));
    chk("rd_data", rd_data, exp_rdd);
    wr_en = we; rd_en = re; addr = a; wr_data = d;
    model_step(we, re, a, d);
  endtask

  task automatic wr(input int a, input int d);
    step(1'b1, 1'b0, ADDR_W'(a), 32'(d));
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, '0, '0);
  endtask

  // run until an interrupt is observed; the next observation is the first of a new period
  task automatic align(input string tag);
    bit found;
    found = 0;
    for (int k = 0; k < 80 && !found; k++) begin
      step(1'b0, 1'b0, '0, '0);
      found = obs_irq;
    end
    chk(tag, 32'(found), 32'd1);
  endtask

  task automatic count(input int n, input int ch, output int hi, output int irqs, output int maxrun);
    int run;
    hi = 0; irqs = 0; maxrun = 0; run = 0;
    for (int k = 0; k < n; k++) begin
      step(1'b0, 1'b0, '0, '0);
      if (obs_pwm[ch]) begin
        hi++; run++;
        if (run > maxrun) maxrun = run;
      end else run = 0;
      if (obs_irq) irqs++;
    end
  endtask

  initial begin
    int hi, irqs, mr;
    bit seen;
    logic [31:0] d;
    int a;

    rst = 1'b1; wr_en = 0; rd_en = 0; addr = '0; wr_data = '0;
    model_reset();
    #12;
    chk("rst_pwm", 32'(pwm_out), 32'd0);
    chk("rst_irq", 32'(period_irq), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_rd_data", rd_data, 32'd0);
    @(negedge clk); rst = 1'b0;
    model_step(1'b0, 1'b0, '0, '0);

    // every mapped register and one unmapped address read back as zero
    for (int i = 0; i < 4 + NCH; i++) step(1'b0, 1'b1, ADDR_W'(i), '0);
    step(1'b0, 1'b1, ADDR_W'(31), '0);
    idle(1);

    // edge mode, period 10 cycles, 3 high
    wr(1, 9); wr(4, 3); wr(2, 1); wr(3, 0); wr(0, 1);
    align("edge_align");
    count(10, 0, hi, irqs, mr);
    chk("edge_hi3", 32'(hi), 32'd3);
    chk("edge_irq", 32'(irqs), 32'd1);
    // duty change mid-period waits for the next period
    hi = 0;
    for (int k = 0; k < 10; k++) begin
      step(k == 2, 1'b0, ADDR_W'(4), 32'd7);
      hi += int'(obs_pwm[0]);
    end
    chk("mid_write_keep3", 32'(hi), 32'd3);
    count(10, 0, hi, irqs, mr);
    chk("next_period_hi7", 32'(hi), 32'd7);

    wr(4, 0);  align("d0_align");  count(10, 0, hi, irqs, mr); chk("duty0_low", 32'(hi), 32'd0);
    wr(4, 10); align("d10_align"); count(10, 0, hi, irqs, mr); chk("duty10_high", 32'(hi), 32'd10);
    wr(3, 1);  align("pol_align"); count(10, 0, hi, irqs, mr); chk("pol_duty10", 32'(hi), 32'd0);
    wr(4, 0);  align("pol0_align"); count(10, 0, hi, irqs, mr); chk("pol_duty0", 32'(hi), 32'd10);

    // centre mode: 16-cycle period; cnt<2 covers 1,0,1 around the trough
    wr(3, 0); wr(2, 2); wr(5, 2); wr(1, 8); wr(0, 3);
    align("ctr_align1"); align("ctr_align2");
    count(8, 1, hi, irqs, mr);
    count(16, 1, hi, irqs, mr);
    chk("ctr_hi", 32'(hi), 32'd3);
    chk("ctr_run", 32'(mr), 32'd3);
    chk("ctr_irq", 32'(irqs), 32'd1);

    // asynchronous reset while the output is high
    wr(1, 9); wr(4, 5); wr(2, 1); wr(0, 1);
    seen = 0;
    for (int k = 0; k < 80 && !seen; k++) begin
      step(1'b0, 1'b0, '0, '0);
      seen = obs_pwm[0];
    end
    chk("pulse_seen", 32'(seen), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_pwm", 32'(pwm_out), 32'd0);
    chk("async_rst_irq", 32'(period_irq), 32'd0);
    model_reset();
    #10;
    @(negedge clk); rst = 1'b0;
    wr_en = 0; rd_en = 0;
    model_step(1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 4 + NCH; i++) step(1'b0, 1'b1, ADDR_W'(i), '0);
    idle(1);

    // randomized register traffic, including same-address read/write collisions
    for (int k = 0; k < 3000; k++) begin
      a = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, NCH + 3));
      if (a == 2 || a == 3) d = $urandom;
      else if (a == 0) begin
        d = $urandom;
        d[0] = ($urandom_range(0, 7) != 0);
      end else begin
        d = 32'($urandom_range(0, 14));
        if ($urandom_range(0, 7) == 0) d = d | ($urandom & 32'hFFFF_0000);
      end
      step(($urandom_range(0, 5) == 0), ($urandom_range(0, 2) == 0), ADDR_W'(a), d);
    end
    idle(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
